dut_8b10b: RTL and testbench
============================

DUT_8B10B -- requirements
Module: dut_8b10b

Interface
REQ-001 CRC_INIT, 32'hFFFFFFFF, CRC32 seed loaded at each packet start.
REQ-002 FIFO_DEPTH, 8, input holding buffer depth; power of two, minimum 4.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 pushin  input  1  datain valid this cycle.
REQ-006 startin  input  1  qualifies the symbol as the packet start; valid only with pushin.
REQ-007 datain  input  9  bit 8 = K (control) flag; bits 7:0 = byte.
REQ-008 pushout  output  1  dataout valid this cycle.
REQ-009 startout  output  1  dataout is the encoded packet-start symbol.
REQ-010 dataout  output  10  8b/10b code group {j,h,g,f,i,e,d,c,b,a}; a = bit 0, transmitted first.

Function
REQ-011 The block SHALL encode every pushed symbol with the standard IBM 8b/10b tables, honouring running disparity (RD).
REQ-012 A symbol with K=1 and a byte outside the 12 legal K codes SHALL be encoded as K28.5.
REQ-013 Packet framing SHALL be: startin with K28.1 (9'h13C) opens the packet; K28.5 (9'h1BC) closes it.
REQ-014 CRC32 SHALL cover only K=0 bytes between the start and end symbols.
REQ-015 CRC32 parameters: reflected polynomial 0xEDB88320, seed CRC_INIT, LSB-first, final XOR 0xFFFFFFFF (Ethernet).
REQ-016 On the end symbol, the block SHALL emit 4 CRC bytes as D codes, least-significant byte first, then the encoded K28.5.
REQ-017 The FSM SHALL have states IDLE, DATA, CRC (2-bit byte counter) and END.
REQ-018 FSM transitions: IDLE->DATA on start; DATA->CRC on K28.5; CRC->END after byte 3; END->IDLE.
REQ-019 Latency SHALL be 2 cycles: a symbol pushed at edge N appears on dataout at edge N+2 when no CRC insertion is pending.
REQ-020 Input SHALL pass through a FIFO_DEPTH FIFO so that symbols pushed during CRC insertion are preserved in order.
REQ-021 The sender SHALL guarantee FIFO_DEPTH is never exceeded; the block has no backpressure output.
REQ-022 On overflow, the incoming symbol SHALL be dropped.
REQ-023 A start received while in DATA SHALL abort the current packet (no CRC emitted), reseed the CRC and open a new packet.
REQ-024 K=0 symbols received in IDLE SHALL be encoded and output, with no CRC update and startout=0.
REQ-025 K codes other than K28.5 inside a packet SHALL be encoded and excluded from the CRC.
REQ-026 startout SHALL be high exactly in the cycle the encoded start symbol is on dataout.
REQ-027 When no symbol is output: pushout=0, startout=0, dataout=10'h000, RD unchanged.
REQ-028 The CRC update SHALL use a combinational 8-bit-per-cycle function.

Reset
REQ-029 While reset=0 at a clock edge, the block SHALL set pushout=0, startout=0, dataout=0, RD=negative, CRC=CRC_INIT, FSM=IDLE and FIFO empty.
REQ-030 A reset asserted mid-packet SHALL discard all in-flight symbols and partial CRC; nothing is output after release until new input arrives.

Configuration
REQ-031 With CRC_APPEND_EN defined, CRC insertion (REQ-014 to REQ-018) SHALL be active.
REQ-032 Without CRC_APPEND_EN, the end symbol SHALL be encoded like any other symbol, no CRC bytes are inserted and CRC logic is omitted; framing and startout are unchanged.

Verification
REQ-033 Reset held low 2 cycles with pushin=1 -> pushout=0, startout=0, dataout=0 throughout.
REQ-034 From reset, push K28.5 twice -> dataout 10'h17C then 10'h283; pushout high both cycles.
REQ-035 Packet K28.1, bytes 0x31..0x39 ("123456789"), K28.5 -> 15 contiguous outputs: 10'h27C with startout=1, 9 data codes, CRC bytes 0x26,0x39,0xF4,0xCB, then K28.5.
REQ-036 Packet K28.1, bytes 0x0A,0x0C,...,0x18, K28.5 with pushin held high, then idle -> CRC bytes match the software model; no symbol lost or reordered.
REQ-037 Same packet as REQ-036 with CRC_APPEND_EN undefined -> 10 outputs, no CRC bytes.
REQ-038 Reset pulsed after the 3rd data byte, then REQ-035 stimulus -> output identical to REQ-035 (fresh RD and CRC).

Source files
------------

// File: rtl/dut_8b10b.sv
// rtl/dut_8b10b.sv - 8b/10b encoder with input FIFO and CRC32 packet trailer (enabled by CRC_APPEND_EN)
module dut_8b10b #(
`ifdef CRC_APPEND_EN
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
`endif
  parameter int          FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushin,
  input  logic       startin,
  input  logic [8:0] datain,
  output logic       pushout,
  output logic       startout,
  output logic [9:0] dataout
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [8:0]  SYM_SOP  = 9'h13C;
  localparam logic [8:0]  SYM_EOP  = 9'h1BC;

  function automatic logic [5:0] lut6(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
      5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;
      5'd14: return 6'b011100;  5'd15: return 6'b010111;
      5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;
      5'd20: return 6'b001011;  5'd21: return 6'b101010;
      5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;
      5'd26: return 6'b010110;  5'd27: return 6'b110110;
      5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  5'd31: return 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] lut4d(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;
      3'd2: return 4'b0101;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  3'd7: return 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] lut4k(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b0110;
      3'd2: return 4'b1010;  3'd3: return 4'b1100;
      3'd4: return 4'b1101;  3'd5: return 4'b0101;
      3'd6: return 4'b1001;  3'd7: return 4'b0111;
    endcase
  endfunction

  function automatic logic legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
  endfunction

  // Input FIFO, entries are {is_start, K, byte}
  logic [9:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop, push_ok;
  logic [9:0]    head;

  assign head    = fifo_mem_q[rd_ptr_q];
  assign push_ok = pushin && ((count_q != FULL_CNT) || pop);

  // FIFO storage needs no reset; only the pointers define occupancy
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= {startin && (datain == SYM_SOP), datain};
  end

  // FIFO pointers and occupancy; pushes into a full FIFO are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // Staged symbol handed to the encoder one cycle after it leaves the FIFO
  logic       sym_v_q, sym_start_q;
  logic [8:0] sym_q;

`ifdef CRC_APPEND_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CRC, ST_END} state_t;
  state_t      state_q;
  logic [1:0]  crc_cnt_q;
  logic [31:0] crc_q, crc_fin;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign crc_fin = ~crc_q;
  assign pop     = (count_q != '0) && ((state_q == ST_IDLE) || (state_q == ST_DATA));

  // Framing FSM: forwards symbols, accumulates CRC and inserts the trailer before the end symbol
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      crc_cnt_q   <= '0;
      crc_q       <= CRC_INIT;
      sym_v_q     <= 1'b0;
      sym_start_q <= 1'b0;
      sym_q       <= '0;
    end else begin
      sym_v_q     <= 1'b0;
      sym_start_q <= 1'b0;
      sym_q       <= '0;
      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (pop) begin
            sym_v_q <= 1'b1;
            sym_q   <= head[8:0];
            if (head[9]) begin
              sym_start_q <= 1'b1;
              crc_q       <= CRC_INIT;
              state_q     <= ST_DATA;
            end else if ((state_q == ST_DATA) && (head[8:0] == SYM_EOP)) begin
              sym_q     <= {1'b0, crc_fin[7:0]};
              crc_cnt_q <= 2'd1;
              state_q   <= ST_CRC;
            end else if ((state_q == ST_DATA) && !head[8]) begin
              crc_q <= crc_byte(crc_q, head[7:0]);
            end
          end
        end
        ST_CRC: begin
          sym_v_q   <= 1'b1;
          sym_q     <= {1'b0, crc_fin[{crc_cnt_q, 3'b000} +: 8]};
          crc_cnt_q <= crc_cnt_q + 2'd1;
          if (crc_cnt_q == 2'd3) state_q <= ST_END;
        end
        ST_END: begin
          sym_v_q <= 1'b1;
          sym_q   <= SYM_EOP;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
`else
  assign pop = (count_q != '0);

  // Forward every FIFO symbol straight to the encoder
  always_ff @(posedge clk) begin
    if (!reset) begin
      sym_v_q     <= 1'b0;
      sym_start_q <= 1'b0;
      sym_q       <= '0;
    end else begin
      sym_v_q     <= pop;
      sym_start_q <= pop && head[9];
      sym_q       <= pop ? head[8:0] : 9'h000;
    end
  end
`endif

  logic [8:0] enc_sym;
  logic [5:0] c6_m, c6;
  logic [3:0] c4_m, c4;
  logic       alt6, alt4, use_a7, rd_q, rd_mid, rd_nxt;
  logic [9:0] enc_code;

  // Encode the staged symbol against the current running disparity
  always_comb begin
    enc_sym = sym_q;
    if (sym_q[8] && !legal_k(sym_q[7:0])) enc_sym = SYM_EOP;
    c6_m = (enc_sym[8] && (enc_sym[4:0] == 5'd28)) ? 6'b001111 : lut6(enc_sym[4:0]);
    alt6 = ($countones(c6_m) != 3) || (enc_sym[4:0] == 5'd7);
    c6   = (rd_q && alt6) ? ~c6_m : c6_m;
    rd_mid = ($countones(c6) == 3) ? rd_q : ~rd_q;
    use_a7 = !enc_sym[8] && (enc_sym[7:5] == 3'd7) &&
             (rd_mid ? ((enc_sym[4:0] == 5'd11) || (enc_sym[4:0] == 5'd13) || (enc_sym[4:0] == 5'd14))
                     : ((enc_sym[4:0] == 5'd17) || (enc_sym[4:0] == 5'd18) || (enc_sym[4:0] == 5'd20)));
    c4_m = lut4d(enc_sym[7:5]);
    alt4 = ($countones(c4_m) != 2) || (enc_sym[7:5] == 3'd3);
    if (enc_sym[8]) begin
      c4_m = lut4k(enc_sym[7:5]);
      alt4 = 1'b1;
    end else if (use_a7) begin
      c4_m = 4'b0111;
      alt4 = 1'b1;
    end
    c4       = (rd_mid && alt4) ? ~c4_m : c4_m;
    rd_nxt   = ($countones(c4) == 2) ? rd_mid : ~rd_mid;
    enc_code = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  end

  // Registered output stage; running disparity only moves when a code group is sent
  always_ff @(posedge clk) begin
    if (!reset) begin
      pushout  <= 1'b0;
      startout <= 1'b0;
      dataout  <= '0;
      rd_q     <= 1'b0;
    end else if (sym_v_q) begin
      pushout  <= 1'b1;
      startout <= sym_start_q;
      dataout  <= enc_code;
      rd_q     <= rd_nxt;
    end else begin
      pushout  <= 1'b0;
      startout <= 1'b0;
      dataout  <= '0;
    end
  end
endmodule

// File: tb/tb_dut_8b10b.sv
// tb/tb_dut_8b10b.sv - self-checking bench for dut_8b10b (follows CRC_APPEND_EN when defined)
module tb_dut_8b10b;
`ifdef CRC_APPEND_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       reset, pushin, startin;
  logic [8:0] datain;
  logic       pushout, startout;
  logic [9:0] dataout;

  dut_8b10b dut (
    .clk(clk), .reset(reset), .pushin(pushin), .startin(startin), .datain(datain),
    .pushout(pushout), .startout(startout), .dataout(dataout)
  );

  always #5 clk = ~clk;

  logic [5:0] M6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                          6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                          6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] P6 [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                          6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                          6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                          6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] DM4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] DP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] KM4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] KP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic [31:0] crc_tab [256];
  logic [10:0] exp_q [$];
  logic [9:0]  stim_q [$];
  logic        ref_rd, in_pkt;
  logic [31:0] crc_m;
  int          vectors = 0, miscompares = 0, cyc = 0;
  int          seg_cnt, seg_first, seg_last;
  logic [10:0] seg_first_word;

  // Returns {rd_after, code}; tables give both disparity columns explicitly
  function automatic logic [10:0] ref_enc(input logic [8:0] s, input logic rd);
    logic       ok, rdm, a7;
    logic [5:0] c6;
    logic [3:0] c4;
    logic [9:0] w, r;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) if (s[7:0] == LEGAL_K[i]) ok = 1'b1;
    if (s[8] && !ok) s = 9'h1BC;
    if (s[8] && s[4:0] == 5'd28) c6 = rd ? 6'b110000 : 6'b001111;
    else c6 = rd ? P6[s[4:0]] : M6[s[4:0]];
    rdm = ($countones(c6) == 3) ? rd : ($countones(c6) == 4);
    if (s[8]) c4 = rdm ? KP4[s[7:5]] : KM4[s[7:5]];
    else begin
      a7 = (s[7:5] == 3'd7) && (rdm ? (s[4:0] inside {5'd11, 5'd13, 5'd14}) : (s[4:0] inside {5'd17, 5'd18, 5'd20}));
      if (a7) c4 = rdm ? 4'b1000 : 4'b0111;
      else c4 = rdm ? DP4[s[7:5]] : DM4[s[7:5]];
    end
    w = {c6, c4};
    for (int i = 0; i < 10; i++) r[i] = w[9-i];
    return {($countones(w) == 5) ? rd : ($countones(w) == 6), r};
  endfunction

  task automatic emit(input logic st, input logic [8:0] s);
    logic [10:0] e;
    e = ref_enc(s, ref_rd);
    ref_rd = e[10];
    exp_q.push_back({st, e[9:0]});
  endtask

  task automatic model_reset();
    exp_q.delete();
    ref_rd = 1'b0;
    in_pkt = 1'b0;
    crc_m  = SEED;
  endtask

  // Packet-level model: what the output stream must contain for one accepted input symbol
  task automatic model_push(input logic s, input logic [8:0] d);
    logic [31:0] fin;
    if (s && d == 9'h13C) begin
      emit(1'b1, d);
      in_pkt = 1'b1;
      crc_m  = SEED;
    end else if (in_pkt && d == 9'h1BC) begin
      fin = crc_m ^ 32'hFFFF_FFFF;
      if (CRC_ON) for (int i = 0; i < 4; i++) emit(1'b0, {1'b0, fin[8*i +: 8]});
      emit(1'b0, d);
      in_pkt = 1'b0;
    end else begin
      if (in_pkt && !d[8]) crc_m = (crc_m >> 8) ^ crc_tab[crc_m[7:0] ^ d[7:0]];
      emit(1'b0, d);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_out();
    logic [10:0] got, want;
    got = {startout, dataout};
    if (pushout === 1'b1) begin
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
      if (seg_cnt == 0) begin seg_first = cyc; seg_first_word = got; end
      seg_last = cyc;
      seg_cnt++;
      check("stream", {21'h0, got}, {21'h0, want});
    end else begin
      check("idle_out", {21'h0, got}, 32'h0);
    end
  endtask

  task automatic tick(input logic r, input logic p, input logic s, input logic [8:0] d);
    reset = r; pushin = p; startin = s; datain = d;
    @(posedge clk);
    cyc++;
    if (!r) model_reset();
    else if (p) model_push(s, d);
    #1;
    check_out();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1'b1, 1'b0, 1'b0, 9'($urandom));
    tick(1'b1, 1'b0, 1'b0, 9'h0);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic play_stim();
    seg_cnt = 0;
    foreach (stim_q[i]) tick(1'b1, 1'b1, stim_q[i][9], stim_q[i][8:0]);
    drain();
  endtask

  task automatic load_check_packet();
    stim_q.delete();
    stim_q.push_back({1'b1, 9'h13C});
    for (int b = 8'h31; b <= 8'h39; b++) stim_q.push_back({2'b00, 8'(b)});
    stim_q.push_back({1'b0, 9'h1BC});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end
    model_reset();
    seg_cnt = 0;

    // Reset held low with traffic on the inputs
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b1, 9'h13C);
      check("rst_pushout", {31'h0, pushout}, 32'h0);
      check("rst_startout", {31'h0, startout}, 32'h0);
      check("rst_dataout", {22'h0, dataout}, 32'h0);
    end

    // Two K28.5 from reset: disparity flip and two-cycle latency
    tick(1'b1, 1'b1, 1'b0, 9'h1BC);
    tick(1'b1, 1'b1, 1'b0, 9'h1BC);
    check("lat_n1_pushout", {31'h0, pushout}, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 9'h0);
    check("k285_first_v", {31'h0, pushout}, 32'h1);
    check("k285_first", {22'h0, dataout}, 32'h17C);
    tick(1'b1, 1'b0, 1'b0, 9'h0);
    check("k285_second_v", {31'h0, pushout}, 32'h1);
    check("k285_second", {22'h0, dataout}, 32'h283);
    drain();

    // Illegal K code maps to K28.5
    tick(1'b0, 1'b0, 1'b0, 9'h0);
    tick(1'b1, 1'b1, 1'b0, 9'h1FF);
    tick(1'b1, 1'b0, 1'b0, 9'h0);
    tick(1'b1, 1'b0, 1'b0, 9'h0);
    check("illegal_k", {22'h0, dataout}, 32'h17C);
    drain();

    // Reference packet "123456789"
    tick(1'b0, 1'b0, 1'b0, 9'h0);
    load_check_packet();
    play_stim();
    check("pkt_count", seg_cnt, CRC_ON ? 32'd15 : 32'd11);
    check("pkt_contig", seg_last - seg_first, seg_cnt - 1);
    check("pkt_sop", {21'h0, seg_first_word}, 32'h67C);

    // Even bytes 0x0A..0x18 back to back
    stim_q.delete();
    stim_q.push_back({1'b1, 9'h13C});
    for (int b = 8'h0A; b <= 8'h18; b += 2) stim_q.push_back({2'b00, 8'(b)});
    stim_q.push_back({1'b0, 9'h1BC});
    play_stim();
    check("even_count", seg_cnt, CRC_ON ? 32'd14 : 32'd10);

    // Start inside a packet aborts it and reseeds
    stim_q.delete();
    stim_q.push_back({1'b1, 9'h13C});
    stim_q.push_back({2'b00, 8'h41});
    stim_q.push_back({2'b00, 8'h42});
    stim_q.push_back({1'b1, 9'h13C});
    stim_q.push_back({2'b00, 8'h43});
    stim_q.push_back({1'b0, 9'h1BC});
    play_stim();
    check("abort_count", seg_cnt, CRC_ON ? 32'd10 : 32'd6);

    // Reset in the middle of a packet, then the reference packet again
    tick(1'b1, 1'b1, 1'b1, 9'h13C);
    tick(1'b1, 1'b1, 1'b0, 9'h031);
    tick(1'b1, 1'b1, 1'b0, 9'h032);
    tick(1'b1, 1'b1, 1'b0, 9'h033);
    tick(1'b0, 1'b0, 1'b0, 9'h0);
    seg_cnt = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 9'h0);
    check("post_rst_quiet", seg_cnt, 32'd0);
    load_check_packet();
    play_stim();
    check("rerun_count", seg_cnt, CRC_ON ? 32'd15 : 32'd11);
    check("rerun_sop", {21'h0, seg_first_word}, 32'h67C);

    // Random traffic, throttled so the FIFO can never overflow
    for (int n = 0; n < 600; n++) begin
      logic       p, s;
      logic [8:0] d;
      int         sel;
      p   = ($urandom_range(0, 1) == 1) && (exp_q.size() <= 6);
      s   = 1'b0;
      sel = $urandom_range(0, 19);
      if (sel < 2) begin s = 1'b1; d = 9'h13C; end
      else if (sel < 4) d = 9'h1BC;
      else if (sel < 5) d = {1'b1, LEGAL_K[$urandom_range(0, 11)]};
      else if (sel < 6 && !in_pkt) d = {1'b1, 8'($urandom)};
      else d = {1'b0, 8'($urandom)};
      tick(1'b1, p, s, d);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
